// File: rtl/imem_loader_arb_pkg.sv
// Shared definitions for the instruction-memory loader/arbiter:
// FSM state encoding and loader constants.
package imem_loader_arb_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_WRITE   = 3'd3,
    ST_FLUSH   = 3'd4,
    ST_RELEASE = 3'd5
  } state_t;

  localparam int LD_BYTES_PER_WORD = 4;
  localparam int RESET_PC_WORD     = 0;

endpackage

// File: rtl/imem_loader_arb_byte_word_packer.sv
// Assembles loader bytes into big-endian 32-bit words. The first byte of a
// word ends up in bits 31:24. A partially filled word is presented with its
// unfilled low bytes forced to zero, so the same output serves both full
// writes and the end-of-image flush.
module imem_loader_arb_byte_word_packer
  import imem_loader_arb_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic [1:0]  byte_idx,
  output logic [31:0] word_out
);

  localparam logic [1:0] LAST_IDX = 2'(LD_BYTES_PER_WORD - 1);

  logic [31:0] shift_reg;
  logic [1:0]  idx_reg;
  logic        full_reg;
  logic [5:0]  pad_shift;

  // Shift bytes in from the right; the index wraps to 0 when a word completes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_reg <= 32'd0;
      idx_reg   <= 2'd0;
      full_reg  <= 1'b0;
    end else if (clear) begin
      shift_reg <= 32'd0;
      idx_reg   <= 2'd0;
      full_reg  <= 1'b0;
    end else if (push) begin
      shift_reg <= {shift_reg[23:0], byte_in};
      idx_reg   <= idx_reg + 2'd1;
      full_reg  <= (idx_reg == LAST_IDX);
    end
  end

  // Left-justify a partial word; shifting by 32 on an empty word yields zero
  always_comb begin
    pad_shift = {3'd4 - {1'b0, idx_reg}, 3'b000};
    if (full_reg) begin
      word_out = shift_reg;
    end else begin
      word_out = shift_reg << pad_shift;
    end
  end

  assign byte_idx = idx_reg;

endmodule

// File: rtl/imem_loader_arb.sv
// Instruction-memory port arbiter and program-loader sequencer.
// Fetch owns the memory port in RUN; otherwise the loader writes assembled
// words sequentially from word 0 and finally holds cpu_reset_req so the CPU
// restarts at PC 0.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to add ld_checksum, the
// XOR of every word written during the current/last load.
module imem_loader_arb
  import imem_loader_arb_pkg::*;
#(
  parameter int ADDR_W         = 14,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_stall,
  input  logic              ld_mode_req,
  input  logic [7:0]        ld_byte,
  input  logic              ld_byte_valid,
  output logic              ld_byte_ready,
  input  logic              ld_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              cpu_reset_req,
  output logic [ADDR_W-1:0] ld_word_cnt,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic [31:0]       ld_checksum,
`endif
  output logic              busy
);

  localparam int         REL_W    = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [1:0] LAST_IDX = 2'(LD_BYTES_PER_WORD - 1);

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr_reg;
  logic [ADDR_W-1:0] cnt_reg;
  logic              done_pend_reg;
  logic [REL_W-1:0]  rel_cnt_reg;

  logic              accept;
  logic              done_now;
  logic              packer_clear;
  logic [1:0]        byte_idx;
  logic [31:0]       packed_word;

  assign accept       = (state_reg == ST_LOAD) && ld_byte_valid;
  assign done_now     = done_pend_reg || ld_done;
  assign packer_clear = (state_reg == ST_DRAIN) || (state_reg == ST_WRITE) ||
                        (state_reg == ST_FLUSH);

  imem_loader_arb_byte_word_packer u_byte_word_packer (
    .clock    (clock),
    .reset    (reset),
    .clear    (packer_clear),
    .push     (accept),
    .byte_in  (ld_byte),
    .byte_idx (byte_idx),
    .word_out (packed_word)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_next    = state_reg;
    fetch_stall   = 1'b1;
    busy          = 1'b1;
    ld_byte_ready = 1'b0;
    mem_we        = 1'b0;
    cpu_reset_req = 1'b0;
    mem_addr      = ptr_reg;
    unique case (state_reg)
      ST_RUN: begin
        fetch_stall = 1'b0;
        busy        = 1'b0;
        mem_addr    = fetch_addr;
        if (ld_mode_req) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_next = ST_LOAD;
      end
      ST_LOAD: begin
        ld_byte_ready = 1'b1;
        if (accept && (byte_idx == LAST_IDX)) begin
          state_next = ST_WRITE;
        end else if (done_now) begin
          // A byte accepted alongside done always leaves a partial word
          state_next = (accept || (byte_idx != 2'd0)) ? ST_FLUSH : ST_RELEASE;
        end
      end
      ST_WRITE: begin
        mem_we     = 1'b1;
        state_next = done_now ? ST_RELEASE : ST_LOAD;
      end
      ST_FLUSH: begin
        mem_we     = 1'b1;
        state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        cpu_reset_req = 1'b1;
        if (rel_cnt_reg == '0) state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Remember an end-of-image pulse until the pending word has been written
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_pend_reg <= 1'b0;
    end else if ((state_reg == ST_DRAIN) || (state_reg == ST_RELEASE)) begin
      done_pend_reg <= 1'b0;
    end else if (((state_reg == ST_LOAD) || (state_reg == ST_WRITE)) && ld_done) begin
      done_pend_reg <= 1'b1;
    end
  end

  // Write pointer and word count; kept separate so the count stays a pure
  // tally even if the load base address ever moves off word 0
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_reg <= ADDR_W'(RESET_PC_WORD);
      cnt_reg <= '0;
    end else if (state_reg == ST_DRAIN) begin
      ptr_reg <= ADDR_W'(RESET_PC_WORD);
      cnt_reg <= '0;
    end else if (mem_we) begin
      ptr_reg <= ptr_reg + ADDR_W'(1);
      cnt_reg <= cnt_reg + ADDR_W'(1);
    end
  end

  // Release timer: loaded on entry, RELEASE exits when it reaches zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rel_cnt_reg <= '0;
    end else if ((state_reg != ST_RELEASE) && (state_next == ST_RELEASE)) begin
      rel_cnt_reg <= REL_W'(RELEASE_CYCLES - 1);
    end else if ((state_reg == ST_RELEASE) && (rel_cnt_reg != '0)) begin
      rel_cnt_reg <= rel_cnt_reg - REL_W'(1);
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_reg;

  // Running XOR of all words committed to memory in this load
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      checksum_reg <= 32'd0;
    end else if (state_reg == ST_DRAIN) begin
      checksum_reg <= 32'd0;
    end else if (mem_we) begin
      checksum_reg <= checksum_reg ^ packed_word;
    end
  end

  assign ld_checksum = checksum_reg;
`endif

  assign mem_wdata   = packed_word;
  assign ld_word_cnt = cnt_reg;

endmodule

// File: tb/tb_imem_loader_arb.sv
// Bench for imem_loader_arb: two instances (ADDR_W=14 and ADDR_W=2) share
// one stimulus stream. A byte-image model predicts the written words and
// addresses; a negedge monitor checks writes and RUN/RELEASE rules.
module tb_imem_loader_arb;

  localparam int AW_A = 14;
  localparam int AW_B = 2;
  localparam int REL  = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [AW_A-1:0] fetch_addr = '0;
  logic            ld_mode_req = 1'b0;
  logic [7:0]      ld_byte = 8'd0;
  logic            ld_byte_valid = 1'b0;
  logic            ld_done = 1'b0;

  logic            fetch_stall_a, ld_byte_ready_a, mem_we_a, cpu_reset_req_a, busy_a;
  logic [AW_A-1:0] mem_addr_a, ld_word_cnt_a;
  logic [31:0]     mem_wdata_a;
  logic            fetch_stall_b, ld_byte_ready_b, mem_we_b, cpu_reset_req_b, busy_b;
  logic [AW_B-1:0] mem_addr_b, ld_word_cnt_b;
  logic [31:0]     mem_wdata_b;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]     ld_checksum_a, ld_checksum_b;
`endif

  always #5 clock = ~clock;

  imem_loader_arb #(.ADDR_W(AW_A), .RELEASE_CYCLES(REL)) dut_a (
    .clock(clock), .reset(reset), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall_a),
    .ld_mode_req(ld_mode_req), .ld_byte(ld_byte), .ld_byte_valid(ld_byte_valid),
    .ld_byte_ready(ld_byte_ready_a), .ld_done(ld_done), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_we(mem_we_a), .cpu_reset_req(cpu_reset_req_a),
    .ld_word_cnt(ld_word_cnt_a),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .ld_checksum(ld_checksum_a),
`endif
    .busy(busy_a));

  imem_loader_arb #(.ADDR_W(AW_B), .RELEASE_CYCLES(REL)) dut_b (
    .clock(clock), .reset(reset), .fetch_addr(fetch_addr[AW_B-1:0]), .fetch_stall(fetch_stall_b),
    .ld_mode_req(ld_mode_req), .ld_byte(ld_byte), .ld_byte_valid(ld_byte_valid),
    .ld_byte_ready(ld_byte_ready_b), .ld_done(ld_done), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_we(mem_we_b), .cpu_reset_req(cpu_reset_req_b),
    .ld_word_cnt(ld_word_cnt_b),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .ld_checksum(ld_checksum_b),
`endif
    .busy(busy_b));

  int n_cmp  = 0;
  int n_fail = 0;

  wr_t        exp_q_a[$];
  wr_t        exp_q_b[$];
  logic [7:0] img[$];
  int         exp_cnt_a, exp_cnt_b;
  int         run_a = 0, run_b = 0, rel_a = 0, rel_b = 0;
  int         rel_exp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: writes against the model queue, RUN-state rules, release length
  always @(negedge clock) begin
    wr_t e;
    chk("stall_eq_busy_a", 32'(fetch_stall_a), 32'(busy_a));
    chk("stall_eq_busy_b", 32'(fetch_stall_b), 32'(busy_b));
    if (!busy_a) begin
      chk("run_addr_a", 32'(mem_addr_a), 32'(fetch_addr));
      chk("run_we_a", 32'(mem_we_a), 0);
      chk("run_ready_a", 32'(ld_byte_ready_a), 0);
      chk("run_rstreq_a", 32'(cpu_reset_req_a), 0);
    end
    if (!busy_b) begin
      chk("run_addr_b", 32'(mem_addr_b), 32'(fetch_addr[AW_B-1:0]));
      chk("run_we_b", 32'(mem_we_b), 0);
    end
    if (mem_we_a) begin
      chk("write_expected_a", 32'(exp_q_a.size() != 0), 1);
      if (exp_q_a.size() != 0) begin
        e = exp_q_a.pop_front();
        chk("waddr_a", 32'(mem_addr_a), e.addr);
        chk("wdata_a", mem_wdata_a, e.data);
      end
    end
    if (mem_we_b) begin
      chk("write_expected_b", 32'(exp_q_b.size() != 0), 1);
      if (exp_q_b.size() != 0) begin
        e = exp_q_b.pop_front();
        chk("waddr_b", 32'(mem_addr_b), e.addr);
        chk("wdata_b", mem_wdata_b, e.data);
      end
    end
    if (cpu_reset_req_a) run_a++;
    else if (run_a != 0) begin
      chk("release_len_a", run_a, REL);
      chk("stall_falls_with_req_a", 32'(fetch_stall_a), 0);
      rel_a++;
      run_a = 0;
    end
    if (cpu_reset_req_b) run_b++;
    else if (run_b != 0) begin
      chk("release_len_b", run_b, REL);
      rel_b++;
      run_b = 0;
    end
  end

  // Model: image bytes -> big-endian zero-padded words at sequential addresses
  task automatic expect_image();
    int  nw;
    wr_t e;
    nw = (img.size() + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      e.data = 32'd0;
      for (int j = 0; j < 4; j++)
        if (4 * k + j < img.size()) e.data[31 - 8 * j -: 8] = img[4 * k + j];
      e.addr = 32'(k % (1 << AW_A));
      exp_q_a.push_back(e);
      e.addr = 32'(k % (1 << AW_B));
      exp_q_b.push_back(e);
    end
    exp_cnt_a = nw % (1 << AW_A);
    exp_cnt_b = nw % (1 << AW_B);
  endtask

  task automatic start_load();
    ld_mode_req = 1'b1;
    @(posedge clock); #1;
    ld_mode_req = 1'b0;
    chk("drain_stall", 32'(fetch_stall_a), 1);
    chk("drain_ready", 32'(ld_byte_ready_a), 0);
    @(posedge clock); #1;
    chk("load_ready", 32'(ld_byte_ready_a), 1);
    chk("cnt_cleared", 32'(ld_word_cnt_a), 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_done, output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    ld_byte = b;
    ld_byte_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (ld_byte_ready_a) begin
        ld_done = with_done;
        got = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clock); #1;
    end
    ld_byte_valid = 1'b0;
    ld_done = 1'b0;
    chk("byte_accepted", 32'(got), 1);
  endtask

  task automatic pulse_done();
    ld_done = 1'b1;
    @(posedge clock); #1;
    ld_done = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(posedge clock); #1;
      idle = !busy_a;
    end
    chk("returned_to_run", 32'(idle), 1);
  endtask

  task automatic run_image(input bit done_with_last);
    int waited;
    start_load();
    for (int i = 0; i < img.size(); i++) begin
      send_byte(img[i], done_with_last && (i == img.size() - 1), waited);
      if (i % 4 == 3) chk("we_after_4th_byte", 32'(mem_we_a), 1);
      if (i % 4 == 0 && i > 0) chk("gap_after_write", waited, 1);
    end
    if (!done_with_last) pulse_done();
    wait_idle();
    @(negedge clock); #1;
    rel_exp++;
    chk("release_count_a", rel_a, rel_exp);
    chk("release_count_b", rel_b, rel_exp);
    chk("word_cnt_a", 32'(ld_word_cnt_a), exp_cnt_a);
    chk("word_cnt_b", 32'(ld_word_cnt_b), exp_cnt_b);
    chk("writes_done_a", exp_q_a.size(), 0);
    chk("writes_done_b", exp_q_b.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fetch_addr = 14'h0123;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_stall", 32'(fetch_stall_a), 0);
    chk("rst_rstreq", 32'(cpu_reset_req_a), 0);
    chk("rst_wdata", mem_wdata_a, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    $display("reset released");
    chk("run_mem_addr", 32'(mem_addr_a), 32'h0123);
    chk("run_mem_we", 32'(mem_we_a), 0);
    chk("run_stall", 32'(fetch_stall_a), 0);
    chk("run_busy", 32'(busy_a), 0);
    chk("run_ready", 32'(ld_byte_ready_a), 0);
    chk("run_cnt", 32'(ld_word_cnt_a), 0);

    // Two full words, done after the last write
    img = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    expect_image();
    chk("model_w0", exp_q_a[0].data, 32'h12345678);
    chk("model_w1", exp_q_a[1].data, 32'h9ABCDEF0);
    run_image(1'b0);
    chk("t1_cnt_literal", 32'(ld_word_cnt_a), 2);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("t1_checksum", ld_checksum_a, 32'h88888888);
`endif
    $display("load 1: 2 words, cnt=%0d", ld_word_cnt_a);

    // Partial word flushed with zero padding
    img = '{8'hAA, 8'hBB};
    expect_image();
    chk("model_flush", exp_q_a[0].data, 32'hAABB0000);
    run_image(1'b0);
    chk("t2_cnt_literal", 32'(ld_word_cnt_a), 1);
    $display("load 2: flush, cnt=%0d", ld_word_cnt_a);

    // done coincident with the 4th byte: exactly one write
    img = '{8'h11, 8'h22, 8'h33, 8'h44};
    expect_image();
    chk("model_coinc", exp_q_a[0].data, 32'h11223344);
    run_image(1'b1);
    $display("load 3: done with 4th byte, cnt=%0d", ld_word_cnt_a);

    // Five words: narrow instance wraps to address 0
    img = '{};
    for (int i = 0; i < 20; i++) img.push_back(8'(8'h30 + i));
    expect_image();
    chk("model_wrap_addr", exp_q_b[4].addr, 0);
    chk("model_wrap_cnt", exp_cnt_b, 1);
    run_image(1'b0);
    chk("t4_cnt_a_literal", 32'(ld_word_cnt_a), 5);
    chk("t4_cnt_b_literal", 32'(ld_word_cnt_b), 1);
    $display("load 4: 5 words, cnt_a=%0d cnt_b=%0d", ld_word_cnt_a, ld_word_cnt_b);

    // Reset in the middle of a load: no write, no restart request
    begin
      int w;
      start_load();
      send_byte(8'hC1, 1'b0, w);
      send_byte(8'hC2, 1'b0, w);
      reset = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy_a), 0);
      chk("midrst_stall", 32'(fetch_stall_a), 0);
      chk("midrst_ready", 32'(ld_byte_ready_a), 0);
      chk("midrst_we", 32'(mem_we_a), 0);
      chk("midrst_rstreq", 32'(cpu_reset_req_a), 0);
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (8) @(posedge clock);
      @(negedge clock); #1;
      chk("midrst_no_release", rel_a, rel_exp);
      chk("midrst_mem_addr", 32'(mem_addr_a), 32'h0123);
      $display("load 5: reset mid-load, releases=%0d", rel_a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader_arb.md
# imem_loader_arb

Program-memory arbiter and loader sequencer for the single-cycle CPU. It shares the instruction memory port between the fetch unit (PC word address) and a byte-stream program loader. It stalls fetch while loading, assembles incoming bytes into 32-bit words and writes them sequentially from word 0. When the load ends it issues a CPU restart request so execution resumes at PC 0.

## Interface
Parameters:
- ADDR_W, 14: instruction-memory word-address width; matches PC[15:2].
- RELEASE_CYCLES, 4: number of cycles `cpu_reset_req` is held after a load.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- fetch_addr  in  ADDR_W  fetch-unit word address
- fetch_stall  out  1  high: fetch must hold PC and ignore instruction
- ld_mode_req  in  1  level request to enter load mode, sampled only in RUN
- ld_byte  in  8  loader data byte
- ld_byte_valid  in  1  byte present
- ld_byte_ready  out  1  arbiter accepts byte this cycle
- ld_done  in  1  single-cycle end-of-image pulse
- mem_addr  out  ADDR_W  address to instruction memory
- mem_wdata  out  32  write data
- mem_we  out  1  write enable, one cycle per word
- cpu_reset_req  out  1  CPU restart request
- ld_word_cnt  out  ADDR_W  words written in current/last load
- busy  out  1  high in every state except RUN

## Operation
- States: RUN, DRAIN, LOAD, WRITE, FLUSH, RELEASE.
- RUN:
  - mem_addr = fetch_addr; mem_we = 0; fetch_stall = 0.
  - ld_mode_req = 1 → DRAIN.
- DRAIN: one cycle; fetch_stall = 1 → LOAD. Clears the byte index, word pointer and ld_word_cnt.
- LOAD:
  - ld_byte_ready = 1; a byte is accepted on valid & ready.
  - Bytes are big-endian: byte index 0 → bits 31:24, index 3 → bits 7:0.
  - Accepting byte index 3 → WRITE.
- WRITE:
  - mem_we = 1, mem_addr = word pointer, mem_wdata = assembled word; ld_byte_ready = 0.
  - Pointer and ld_word_cnt increment; → LOAD, or → FLUSH/RELEASE if a done is pending.
- ld_done handling:
  - Seen in LOAD or WRITE, or together with an accepted byte, it sets a pending flag. The byte is accepted first.
  - If the byte index is 0, → RELEASE.
  - Otherwise → FLUSH. FLUSH writes the partial word with unfilled low bytes zero, counts it, then → RELEASE.
- RELEASE:
  - cpu_reset_req = 1 and fetch_stall = 1 for RELEASE_CYCLES cycles, then → RUN.
- Word pointer wraps from 2^ADDR_W−1 to 0; ld_word_cnt wraps identically.
- ld_mode_req is ignored outside RUN. It is level-sensitive: a request still high on return to RUN starts a new load.
- In non-RUN states, mem_addr = word pointer and fetch_addr is ignored.

## Timing
- Reset values: state RUN, fetch_stall 0, ld_byte_ready 0, mem_we 0, mem_wdata 0, cpu_reset_req 0, ld_word_cnt 0, busy 0.
- Asserting reset mid-load returns to RUN immediately. A word not yet written is lost, and no cpu_reset_req is issued.
- fetch_stall, busy, ld_byte_ready, mem_we and mem_addr are decoded from the state register. Only the RUN-state mem_addr path is combinational from fetch_addr.
- Timing for 4 accepted bytes:
  - Rising edge after the 4th byte → WRITE.
  - mem_we is high for exactly that cycle.
  - The next byte can be accepted 2 cycles after the 4th.
- ld_mode_req high at edge N → fetch_stall high from N+1. The first byte can be accepted at edge N+2.
- End of load: RELEASE starts 1 cycle after the final write (or the done pulse). fetch_stall falls on the same edge cpu_reset_req falls.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - Adds output `ld_checksum` (32 bits): XOR of every word written, including a flushed partial word.
  - Cleared in DRAIN, held after RELEASE, reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package: state encoding enum and constants LD_BYTES_PER_WORD = 4 and RESET_PC_WORD = 0.
- One natural sub-module: `byte_word_packer`. It holds the byte index, shift register, full flag and zero-pad flush logic.
- The FSM, pointer and release counter stay in the top module.

## Test plan
- Reset, RUN, fetch_addr=0x0123 → mem_addr=0x0123, mem_we=0, fetch_stall=0, busy=0.
- ld_mode_req, then bytes 12 34 56 78 9A BC DE F0, then ld_done → writes 0x12345678@0 and 0x9ABCDEF0@1. ld_word_cnt=2, cpu_reset_req high exactly 4 cycles, then RUN.
- Bytes AA BB, then ld_done → FLUSH writes 0xAABB0000@0; ld_word_cnt=1.
- ld_done coincident with 4th byte 0x44 of 11 22 33 44 → one write 0x11223344, then RELEASE with no extra write.
- ADDR_W=2 with 5 words → 5th word written at address 0; ld_word_cnt=1.
- reset asserted during LOAD after 2 bytes → immediate RUN, no mem_we, cpu_reset_req stays 0. With the macro defined, checksum after the words 0x12345678 and 0x9ABCDEF0 = 0x88888888.
